// File: rtl/gate_vector_decoder.sv
// Serial receiver for the 8-bit gate response vector F[0:7]: recovers the stimulus
// i[1:0], flags vectors inconsistent with it and counts bad or truncated frames.
module gate_vector_decoder #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_first,
    output logic             s_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [0:7]       m_F,
    output logic [1:0]       m_i,
    output logic             m_err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t     state, state_nxt;
    logic [2:0] idx;
    logic [0:7] f_buf;
    logic [0:7] f_full;
    logic [0:7] f_exp;
    logic       a, b;
    logic       accept, resync, frame_done, bad_frame;

    assign accept     = s_valid && s_ready;
    assign resync     = accept && (state == SHIFT) && s_first;
    assign frame_done = accept && (state == SHIFT) && !s_first && (idx == 3'd7);

    // Decode sees the complete vector in the same cycle F[7] arrives.
    always_comb begin
        f_full    = f_buf;
        f_full[7] = s_data;
    end

    assign a         = f_full[0];
    assign b         = f_full[0] ^ f_full[6];
    assign f_exp     = {a, ~a, a & b, a | b, ~(a | b), ~(a & b), a ^ b, ~(a ^ b)};
    assign bad_frame = (f_full != f_exp);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && s_first) state_nxt = SHIFT;
            SHIFT:   if (frame_done)        state_nxt = HOLD;
            HOLD:    if (m_ready)           state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = !rst && (state != HOLD);
        m_valid = (state == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            f_buf     <= '0;
            m_F       <= '0;
            m_i       <= '0;
            m_err     <= 1'b0;
            err_count <= '0;
        end else begin
            if (accept) begin
                if (s_first) begin
                    f_buf[0] <= s_data;
                    idx      <= 3'd1;
                end else if (state == SHIFT) begin
                    f_buf[idx] <= s_data;
                    idx        <= idx + 3'd1;
                end
            end
            if (frame_done) begin
                m_F   <= f_full;
                m_i   <= {a, b};
                m_err <= bad_frame;
            end
            if ((resync || (frame_done && bad_frame)) && (err_count != '1))
                err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_gate_vector_decoder.sv
// Self-checking bench for gate_vector_decoder: directed frames plus randomized
// frames against a gate-level truth-table model; a second ERR_W=2 instance covers saturation.
module tb_gate_vector_decoder;

    logic clk = 1'b0;
    logic rst, s_valid, s_data, s_first, m_ready;

    logic       s_ready8, m_valid8, m_err8;
    logic [0:7] m_F8;
    logic [1:0] m_i8;
    logic [7:0] err_count8;

    logic       s_ready2, m_valid2, m_err2;
    logic [0:7] m_F2;
    logic [1:0] m_i2;
    logic [1:0] err_count2;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    gate_vector_decoder #(.ERR_W(8)) dut8 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_first(s_first),
        .s_ready(s_ready8), .m_valid(m_valid8), .m_ready(m_ready), .m_F(m_F8),
        .m_i(m_i8), .m_err(m_err8), .err_count(err_count8)
    );

    gate_vector_decoder #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_first(s_first),
        .s_ready(s_ready2), .m_valid(m_valid2), .m_ready(m_ready), .m_F(m_F2),
        .m_i(m_i2), .m_err(m_err2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response of the gate block for stimulus i: buf, not, and, or, nor, nand, xor, xnor.
    function automatic logic [0:7] gate_vec(input logic [1:0] i);
        logic [0:7] v;
        logic x, y;
        x = i[1];
        y = i[0];
        v = '0;
        for (int g = 0; g < 8; g++) begin
            case (g)
                0: v[g] = x;
                1: v[g] = !x;
                2: v[g] = x && y;
                3: v[g] = x || y;
                4: v[g] = !(x || y);
                5: v[g] = !(x && y);
                6: v[g] = x != y;
                default: v[g] = x == y;
            endcase
        end
        return v;
    endfunction

    // F[0] is the buf output (x); F[6] is the xor output, so y = F[0]^F[6].
    function automatic logic [1:0] rx_i(input logic [0:7] f);
        return {f[0], f[0] ^ f[6]};
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic d, input logic first);
        s_valid = 1'b1;
        s_data  = d;
        s_first = first;
        tick();
        s_valid = 1'b0;
        s_first = 1'b0;
        s_data  = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cnt8"}, 32'(err_count8), 32'(sat(exp_cnt, 255)));
        check({tag, "_cnt2"}, 32'(err_count2), 32'(sat(exp_cnt, 3)));
    endtask

    task automatic send_frame(input logic [0:7] f, input int max_gap, input bit resync);
        logic [1:0] ei;
        logic       ee;
        for (int k = 0; k < 8; k++) begin
            if (k > 0 && max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
            if (k == 7) check("pre_last_mvalid", 32'(m_valid8), 32'd0);
            beat(f[k], k == 0);
            if (k == 0 && resync) begin
                exp_cnt++;
                check_counts("resync");
            end
        end
        ei = rx_i(f);
        ee = (f != gate_vec(ei));
        if (ee) exp_cnt++;
        check("m_valid", 32'(m_valid8), 32'd1);
        check("s_ready_hold", 32'(s_ready8), 32'd0);
        check("m_F", 32'(m_F8), 32'(f));
        check("m_i", 32'(m_i8), 32'(ei));
        check("m_err", 32'(m_err8), 32'(ee));
        check_counts("frame");
    endtask

    // Hold m_ready low for `hold` cycles while throwing ignored beats, then handshake.
    task automatic take(input int hold);
        logic [0:7] f0;
        f0 = m_F8;
        for (int c = 0; c < hold; c++) begin
            s_valid = 1'b1;
            s_data  = 1'($urandom_range(0, 1));
            s_first = 1'($urandom_range(0, 1));
            tick();
            check("hold_mvalid", 32'(m_valid8), 32'd1);
            check("hold_sready", 32'(s_ready8), 32'd0);
            check("hold_mF", 32'(m_F8), 32'(f0));
        end
        s_valid = 1'b0;
        s_first = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("post_hs_mvalid", 32'(m_valid8), 32'd0);
        check("post_hs_sready", 32'(s_ready8), 32'd1);
    endtask

    initial begin
        logic [0:7] f;
        rst = 1'b1; s_valid = 1'b0; s_data = 1'b0; s_first = 1'b0; m_ready = 1'b0;
        repeat (2) tick();
        check("rst_sready", 32'(s_ready8), 32'd0);
        check("rst_mvalid", 32'(m_valid8), 32'd0);
        check("rst_mF", 32'(m_F8), 32'd0);
        check("rst_mi", 32'(m_i8), 32'd0);
        check("rst_merr", 32'(m_err8), 32'd0);
        check_counts("rst");
        rst = 1'b0;
        #1;
        check("idle_sready", 32'(s_ready8), 32'd1);

        // Clean frames for every stimulus, back-to-back.
        for (int i = 0; i < 4; i++) begin
            send_frame(gate_vec(2'(i)), 0, 0);
            take(0);
        end

        // i=01 with F[7] flipped, held for 5 cycles.
        f = gate_vec(2'b01);
        f[7] = ~f[7];
        send_frame(f, 0, 0);
        take(5);

        // Junk in IDLE, then a truncated frame followed by a resync into i=11.
        repeat (3) beat(1'b1, 1'b0);
        check("junk_mvalid", 32'(m_valid8), 32'd0);
        check_counts("junk");
        beat(1'b1, 1'b1);
        repeat (3) beat(1'b0, 1'b0);
        send_frame(gate_vec(2'b11), 0, 1);
        take(1);

        // Further bad frames push the 2-bit counter into saturation.
        for (int n = 0; n < 3; n++) begin
            f = gate_vec(2'($urandom_range(0, 3)));
            f[2] = ~f[2];
            send_frame(f, 1, 0);
            take(0);
        end

        // Randomized frames with gaps and occasional single-bit corruption.
        for (int n = 0; n < 24; n++) begin
            int pos;
            f = gate_vec(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) begin
                pos = int'($urandom_range(0, 7));
                f[pos] = ~f[pos];
            end
            send_frame(f, 2, 0);
            take(int'($urandom_range(0, 3)));
        end

        // Reset at idx 4 of a frame.
        f = gate_vec(2'b10);
        for (int k = 0; k < 4; k++) beat(f[k], k == 0);
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        check("mid_rst_sready", 32'(s_ready8), 32'd0);
        check("mid_rst_mvalid", 32'(m_valid8), 32'd0);
        check("mid_rst_mF", 32'(m_F8), 32'd0);
        check("mid_rst_mi", 32'(m_i8), 32'd0);
        check("mid_rst_merr", 32'(m_err8), 32'd0);
        check_counts("mid_rst");
        tick();
        rst = 1'b0;
        send_frame(gate_vec(2'b10), 0, 0);
        take(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_vector_decoder.md
# gate_vector_decoder

Serial receiver and checker for the 8-bit logic-gate response vector F[0:7] produced by the two-input gate exercise block (buf, not, and, or, nor, nand, xor, xnor of i[1:0]). It collects the vector one bit per accepted beat, recovers the 2-bit stimulus i[1:0] and checks that all eight bits agree with that stimulus. It presents the result on a valid/ready output and keeps a saturating count of bad frames. It sits on the far end of a serial link from the gate block's output, as the self-check path for that block.

## Interface

Parameters:
- ERR_W, default 8: width of err_count.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- s_valid, input, 1: serial bit present on s_data.
- s_data, input, 1: serial bit; F[0] first, F[7] last.
- s_first, input, 1: marks the current bit as F[0] (frame start).
- s_ready, output, 1: decoder accepts a bit this cycle.
- m_valid, output, 1: decoded frame available.
- m_ready, input, 1: downstream takes the frame.
- m_F, output, 8 (indexed [0:7]): received vector.
- m_i, output, 2: recovered stimulus i[1:0].
- m_err, output, 1: received vector inconsistent with m_i.
- err_count, output, ERR_W: number of bad or truncated frames; saturates at all-ones.

## Operation

- A beat is accepted when s_valid && s_ready.
- States:
  - IDLE: s_ready=1. An accepted beat with s_first=0 is discarded. An accepted beat with s_first=1 stores F[0]=s_data, sets bit index to 1 and goes to SHIFT.
  - SHIFT: s_ready=1. An accepted beat with s_first=0 stores F[idx]=s_data and increments idx. Accepting idx 7 goes to HOLD.
  - SHIFT, resync: an accepted beat with s_first=1 aborts the partial frame, increments err_count (saturating), stores the new F[0], sets idx=1 and stays in SHIFT.
  - HOLD: s_ready=0, m_valid=1, outputs stable. When m_valid && m_ready, go to IDLE on the next edge.
- Decode rules, applied on entry to HOLD:
  - a=F[0], b=F[0]^F[6], m_i={a,b}.
  - Expected vector: E = {a, ~a, a&b, a|b, ~(a|b), ~(a&b), a^b, ~(a^b)}, listed for indices 0..7.
  - m_err = (F != E).
  - If m_err=1, err_count increments, saturating at 2^ERR_W-1.
- m_F, m_i and m_err change only when entering HOLD.
- rst forces s_ready=0 combinationally while high. Reset mid-frame discards the partial frame without counting it.

## Timing

- Reset values: state=IDLE, s_ready=0 while rst=1, then 1 in IDLE; m_valid=0, m_F=0, m_i=0, m_err=0, err_count=0.
- Back-to-back beats: F[0] accepted at edge 0 and F[7] at edge 7. m_valid=1 in the cycle after edge 7, i.e. 1 cycle of decode latency after the last bit.
- m_valid stays high until the handshake. After the handshake edge, m_valid=0 and s_ready=1.
- No beat is accepted in the handshake cycle, so the minimum frame period is 9 cycles plus the HOLD time.
- The err_count update and m_valid assertion happen on the same edge.
- s_valid gaps in SHIFT only stall collection. There is no timeout.

## Test plan

- Reset, then send i=00 frame 0,1,0,0,1,1,0,1 back-to-back with m_ready=1 -> m_valid in cycle 8, m_i=00, m_err=0, err_count=0; one-cycle m_valid pulse.
- Send frames for i=01 (0,1,0,1,0,1,1,0), i=10 (1,0,0,1,0,1,1,0) and i=11 (1,0,1,1,0,0,0,1) -> m_i=01, 10, 11 respectively, all m_err=0.
- Send i=01 frame with F[7] flipped (0,1,0,1,0,1,1,1) -> m_i=01, m_err=1, err_count=1. Hold m_ready=0 for 5 cycles: outputs stable, s_ready=0, extra s_valid beats ignored.
- Send s_first frame start, 3 bits, then a new s_first and a full i=11 frame -> err_count+1 for the truncated frame, then m_i=11, m_err=0. Beats with s_first=0 in IDLE before any frame start are ignored.
- With ERR_W=2, send 5 bad frames -> err_count saturates at 3.
- Assert rst at idx 4 of a frame -> all outputs return to reset values immediately, err_count=0, and the next full frame decodes correctly.
